vid_mem_arbiter: RTL and testbench



---
 rtl/vid_mem_arbiter_if.sv | 37 +++
 rtl/vid_mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_vid_mem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vid_mem_arbiter_if.sv
// rtl/vid_mem_arbiter_if.sv - frame-buffer memory command/beat port shared by the arbiter and memory controller
//   mem_cmd_valid/ready : command handshake
//   mem_cmd_write       : 1 = write burst, 0 = read burst
//   mem_cmd_addr        : burst start byte address
//   mem_cmd_len         : beats per burst minus one
//   mem_wbeat/mem_rbeat : one write beat accepted / one read beat returned
interface vid_mem_arbiter_if #(
    parameter int ADDR_W = 28
);
    logic              mem_cmd_valid;
    logic              mem_cmd_ready;
    logic              mem_cmd_write;
    logic [ADDR_W-1:0] mem_cmd_addr;
    logic [7:0]        mem_cmd_len;
    logic              mem_wbeat;
    logic              mem_rbeat;

    modport master (
        output mem_cmd_valid,
        output mem_cmd_write,
        output mem_cmd_addr,
        output mem_cmd_len,
        input  mem_cmd_ready,
        input  mem_wbeat,
        input  mem_rbeat
    );

    modport slave (
        input  mem_cmd_valid,
        input  mem_cmd_write,
        input  mem_cmd_addr,
        input  mem_cmd_len,
        output mem_cmd_ready,
        output mem_wbeat,
        output mem_rbeat
    );
endinterface

// File: rtl/vid_mem_arbiter.sv
// rtl/vid_mem_arbiter.sv - burst scheduler sharing one frame-buffer port among cmos1, cmos2 and HDMI
//   clk, rst     : clock, synchronous active-high reset
//   req[2:0]     : burst request (0 cmos1 write, 1 cmos2 write, 2 HDMI read)
//   frame_start  : per-requester pulse restarting its address at its base
//   urgent       : HDMI FIFO below low watermark, HDMI takes strict priority
//   grant[2:0]   : one-hot burst owner, held from arbitration through burst_done
//   burst_done   : one-cycle pulse at burst end
//   mem          : memory command/beat port (master side)
module vid_mem_arbiter #(
    parameter int                ADDR_W      = 28,
    parameter int                BURST_LEN   = 16,
    parameter int                BEAT_BYTES  = 32,
    parameter int                FRAME_BYTES = 1280*720*2,
    parameter logic [ADDR_W-1:0] CAM1_BASE   = ADDR_W'('h0),
    parameter logic [ADDR_W-1:0] CAM2_BASE   = ADDR_W'('h0200000),
    parameter logic [ADDR_W-1:0] DISP_BASE   = ADDR_W'('h0400000)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2:0]              req,
    input  logic [2:0]              frame_start,
    input  logic                    urgent,
    output logic [2:0]              grant,
    output logic                    burst_done,
    vid_mem_arbiter_if.master       mem
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(BURST_LEN * BEAT_BYTES);
    localparam logic [ADDR_W-1:0] FRAME     = ADDR_W'(FRAME_BYTES);
    localparam logic [8:0]        LAST_BEAT = 9'(BURST_LEN);

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        rr_ptr;
    logic [1:0]        own_idx;
    logic              own_urgent;
    logic [1:0]        win_idx;
    logic              win_urgent;
    logic              win_found;
    logic [1:0]        cand;
    logic              beat_in;
    logic [8:0]        beat_cnt;
    logic [2:0]        pending;
    logic [ADDR_W-1:0] offset [3];

    function automatic logic [ADDR_W-1:0] base_of(input logic [1:0] idx);
        case (idx)
            2'd0:    base_of = CAM1_BASE;
            2'd1:    base_of = CAM2_BASE;
            default: base_of = DISP_BASE;
        endcase
    endfunction

    assign mem.mem_cmd_len = 8'(BURST_LEN - 1);

    // Winner for the next burst: urgent HDMI overrides, otherwise round-robin
    // starting just after the last non-urgent owner.
    always_comb begin
        win_idx    = 2'd0;
        win_urgent = 1'b0;
        win_found  = 1'b0;
        cand       = 2'd0;
        if (urgent && req[2]) begin
            win_idx    = 2'd2;
            win_urgent = 1'b1;
        end else begin
            for (int k = 1; k <= 3; k++) begin
                cand = 2'((int'(rr_ptr) + k) % 3);
                if (!win_found && req[cand]) begin
                    win_idx   = cand;
                    win_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt         = state;
        mem.mem_cmd_valid = 1'b0;
        burst_done        = 1'b0;
        beat_in           = mem.mem_cmd_write ? mem.mem_wbeat : mem.mem_rbeat;
        case (state)
            IDLE: begin
                if (|req) state_nxt = CMD;
            end
            CMD: begin
                mem.mem_cmd_valid = 1'b1;
                if (mem.mem_cmd_ready) state_nxt = DATA;
            end
            DATA: begin
                if (beat_cnt == LAST_BEAT) state_nxt = DONE;
            end
            DONE: begin
                burst_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant             <= 3'b000;
            own_idx           <= 2'd0;
            own_urgent        <= 1'b0;
            rr_ptr            <= 2'd2;
            mem.mem_cmd_write <= 1'b0;
            mem.mem_cmd_addr  <= '0;
            beat_cnt          <= 9'd0;
            pending           <= 3'b000;
            for (int i = 0; i < 3; i++) offset[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant             <= 3'b001 << win_idx;
                        own_idx           <= win_idx;
                        own_urgent        <= win_urgent;
                        mem.mem_cmd_write <= (win_idx != 2'd2);
                        // A restart arriving with the arbitration edge already points at the base.
                        mem.mem_cmd_addr  <= frame_start[win_idx] ? base_of(win_idx)
                                                                  : base_of(win_idx) + offset[win_idx];
                    end
                end
                CMD: begin
                    if (mem.mem_cmd_ready) beat_cnt <= beat_in ? 9'd1 : 9'd0;
                end
                DATA: begin
                    if (beat_in && beat_cnt != LAST_BEAT) beat_cnt <= beat_cnt + 9'd1;
                end
                DONE: begin
                    grant <= 3'b000;
                    if (!own_urgent) rr_ptr <= own_idx;
                end
                default: ;
            endcase

            for (int i = 0; i < 3; i++) begin
                if (state == DONE && own_idx == 2'(i)) begin
                    if (pending[i] || frame_start[i])   offset[i] <= '0;
                    else if (offset[i] + STEP >= FRAME) offset[i] <= '0;
                    else                                offset[i] <= offset[i] + STEP;
                    pending[i] <= 1'b0;
                end else if ((state == CMD || state == DATA) && own_idx == 2'(i)) begin
                    // The owner's address is in flight; defer the restart to burst end.
                    if (frame_start[i]) pending[i] <= 1'b1;
                end else if (frame_start[i]) begin
                    offset[i] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_vid_mem_arbiter.sv
// tb/tb_vid_mem_arbiter.sv - self-checking bench for vid_mem_arbiter
module tb_vid_mem_arbiter;

    localparam int                ADDR_W      = 28;
    localparam int                BURST_LEN   = 16;
    localparam int                BEAT_BYTES  = 32;
    localparam int                FRAME_BYTES = 2048;
    localparam int                STEP        = BURST_LEN * BEAT_BYTES;
    localparam logic [ADDR_W-1:0] CAM1_BASE   = ADDR_W'('h0);
    localparam logic [ADDR_W-1:0] CAM2_BASE   = ADDR_W'('h0200000);
    localparam logic [ADDR_W-1:0] DISP_BASE   = ADDR_W'('h0400000);

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [2:0] frame_start;
    logic       urgent;
    logic [2:0] grant;
    logic       burst_done;

    vid_mem_arbiter_if #(.ADDR_W(ADDR_W)) mem_bus ();

    vid_mem_arbiter #(
        .ADDR_W     (ADDR_W),
        .BURST_LEN  (BURST_LEN),
        .BEAT_BYTES (BEAT_BYTES),
        .FRAME_BYTES(FRAME_BYTES),
        .CAM1_BASE  (CAM1_BASE),
        .CAM2_BASE  (CAM2_BASE),
        .DISP_BASE  (DISP_BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .frame_start(frame_start),
        .urgent     (urgent),
        .grant      (grant),
        .burst_done (burst_done),
        .mem        (mem_bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int  rr_m;
    int  off_m [3];
    bit  pend_m [3];

    // Observed command of the most recent burst
    logic [2:0]        obs_gnt;
    logic [ADDR_W-1:0] obs_addr;
    logic              obs_wr;

    function automatic logic [ADDR_W-1:0] base_of(input int i);
        if (i == 0)      return CAM1_BASE;
        else if (i == 1) return CAM2_BASE;
        else             return DISP_BASE;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        rr_m = 2;
        for (int i = 0; i < 3; i++) begin
            off_m[i]  = 0;
            pend_m[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_bus.mem_cmd_ready = 1'b0;
        mem_bus.mem_wbeat = 1'b0;
        mem_bus.mem_rbeat = 1'b0;
        frame_start = 3'b000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One complete burst as seen by the memory controller. Called at a negedge
    // just before the arbitration edge; returns at the negedge of the idle cycle
    // that follows burst_done.
    task automatic do_burst(input int rdy_dly, input bit cmd_beat, input bit dense, input bit junk,
                            input logic [2:0] fs_mask, input logic [2:0] req_mid, input int abort_at);
        int  w;
        bit  urg;
        int  waited;
        int  given;
        int  iter;
        bit  wr;
        bit  good;
        bit  bad;
        logic [ADDR_W-1:0] exp_addr;

        w   = -1;
        urg = 1'b0;
        if (urgent && req[2]) begin
            w   = 2;
            urg = 1'b1;
        end else begin
            for (int k = 1; k <= 3; k++) begin
                if (w < 0 && req[(rr_m + k) % 3]) w = (rr_m + k) % 3;
            end
        end
        if (w < 0) w = 0;
        wr       = (w != 2);
        exp_addr = base_of(w) + ADDR_W'(off_m[w]);

        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!mem_bus.mem_cmd_valid && waited < 8);
        check("cmd_latency", waited, 1);
        obs_gnt  = grant;
        obs_addr = mem_bus.mem_cmd_addr;
        obs_wr   = mem_bus.mem_cmd_write;
        if (!mem_bus.mem_cmd_valid) return;

        for (int d = 0; d <= rdy_dly; d++) begin
            if (d > 0) @(negedge clk);
            check("cmd_valid", mem_bus.mem_cmd_valid, 1);
            check("cmd_grant", grant, 32'(1 << w));
            check("cmd_write", mem_bus.mem_cmd_write, wr);
            check("cmd_addr", mem_bus.mem_cmd_addr, exp_addr);
            check("cmd_len", mem_bus.mem_cmd_len, BURST_LEN - 1);
            check("cmd_no_done", burst_done, 0);
        end

        mem_bus.mem_cmd_ready = 1'b1;
        if (wr) mem_bus.mem_wbeat = cmd_beat;
        else    mem_bus.mem_rbeat = cmd_beat;
        @(negedge clk);
        mem_bus.mem_cmd_ready = 1'b0;
        given = cmd_beat ? 1 : 0;

        iter = 0;
        while (given < BURST_LEN && iter < 400) begin
            check("data_no_done", burst_done, 0);
            check("data_valid_low", mem_bus.mem_cmd_valid, 0);
            if (given == abort_at) begin
                rst = 1'b1;
                mem_bus.mem_wbeat = 1'b0;
                mem_bus.mem_rbeat = 1'b0;
                frame_start = 3'b000;
                @(negedge clk);
                check("rst_grant", grant, 0);
                check("rst_valid", mem_bus.mem_cmd_valid, 0);
                check("rst_done", burst_done, 0);
                check("rst_addr", mem_bus.mem_cmd_addr, 0);
                rst = 1'b0;
                model_reset();
                return;
            end
            good = dense ? 1'b1 : ($urandom_range(0, 3) != 0);
            bad  = junk & ($urandom_range(0, 1) == 1);
            mem_bus.mem_wbeat = wr ? good : bad;
            mem_bus.mem_rbeat = wr ? bad : good;
            if (iter == 2) begin
                frame_start = fs_mask;
                for (int i = 0; i < 3; i++) begin
                    if (fs_mask[i]) begin
                        if (i == w) pend_m[i] = 1'b1;
                        else        off_m[i]  = 0;
                    end
                end
            end else begin
                frame_start = 3'b000;
            end
            if (iter == 3 && req_mid != 3'b000) req = req_mid;
            if (good) given++;
            iter++;
            @(negedge clk);
        end
        mem_bus.mem_wbeat = 1'b0;
        mem_bus.mem_rbeat = 1'b0;
        frame_start = 3'b000;

        waited = 0;
        while (!burst_done && waited < 4) begin
            @(negedge clk);
            waited++;
        end
        check("done_seen", burst_done, 1);
        check("done_after_last_beat", waited, 1);
        check("done_grant", grant, 32'(1 << w));

        if (pend_m[w]) off_m[w] = 0;
        else           off_m[w] = (off_m[w] + STEP) % FRAME_BYTES;
        pend_m[w] = 1'b0;
        if (!urg) rr_m = w;

        @(negedge clk);
        check("idle_valid", mem_bus.mem_cmd_valid, 0);
        check("idle_grant", grant, 0);
        check("idle_done", burst_done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] wrap_addr [5];
        logic [2:0]        r;

        rst = 1'b1;
        req = 3'b000;
        frame_start = 3'b000;
        urgent = 1'b0;
        mem_bus.mem_cmd_ready = 1'b0;
        mem_bus.mem_wbeat = 1'b0;
        mem_bus.mem_rbeat = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);

        check("reset_grant", grant, 0);
        check("reset_valid", mem_bus.mem_cmd_valid, 0);
        check("reset_write", mem_bus.mem_cmd_write, 0);
        check("reset_addr", mem_bus.mem_cmd_addr, 0);
        check("reset_done", burst_done, 0);
        check("reset_len", mem_bus.mem_cmd_len, BURST_LEN - 1);

        // Round-robin order with all three requesting
        req = 3'b111;
        rst = 1'b0;
        do_burst(0, 1, 1, 0, 3'b000, 3'b000, -1);
        check("rr0_grant", obs_gnt, 3'b001);
        check("rr0_addr", obs_addr, CAM1_BASE);
        do_burst(0, 1, 1, 0, 3'b000, 3'b000, -1);
        check("rr1_grant", obs_gnt, 3'b010);
        check("rr1_addr", obs_addr, CAM2_BASE);
        do_burst(0, 1, 1, 0, 3'b000, 3'b000, -1);
        check("rr2_grant", obs_gnt, 3'b100);
        check("rr2_addr", obs_addr, DISP_BASE);
        check("rr2_write", obs_wr, 0);
        do_burst(0, 1, 1, 0, 3'b000, 3'b000, -1);
        check("rr3_grant", obs_gnt, 3'b001);
        check("rr3_addr", obs_addr, CAM1_BASE + ADDR_W'(STEP));

        // Urgent HDMI override does not advance the round-robin pointer
        do_reset();
        req = 3'b011;
        urgent = 1'b1;
        do_burst(0, 0, 0, 0, 3'b000, 3'b111, -1);
        check("urg0_grant", obs_gnt, 3'b001);
        do_burst(0, 0, 0, 0, 3'b000, 3'b000, -1);
        check("urg1_grant", obs_gnt, 3'b100);
        urgent = 1'b0;
        req = 3'b011;
        do_burst(0, 0, 0, 0, 3'b000, 3'b000, -1);
        check("urg2_grant", obs_gnt, 3'b010);

        // frame_start on the owner mid-burst restarts its next burst at the base
        req = 3'b010;
        do_burst(1, 0, 0, 0, 3'b010, 3'b000, -1);
        check("fs0_addr", obs_addr, CAM2_BASE + ADDR_W'(STEP));
        do_burst(0, 1, 1, 0, 3'b000, 3'b000, -1);
        check("fs1_addr", obs_addr, CAM2_BASE);

        // Ready held off, read beats during a write burst ignored
        req = 3'b001;
        do_burst(5, 0, 0, 1, 3'b000, 3'b000, -1);
        check("stall_addr", obs_addr, CAM1_BASE + ADDR_W'(STEP));

        // Offset wrap at the end of the frame
        do_reset();
        req = 3'b001;
        for (int b = 0; b < 5; b++) begin
            do_burst(0, 1, 1, 0, 3'b000, 3'b000, -1);
            wrap_addr[b] = obs_addr;
        end
        check("wrap0", wrap_addr[0], CAM1_BASE);
        check("wrap1", wrap_addr[1], CAM1_BASE + ADDR_W'(STEP));
        check("wrap3", wrap_addr[3], CAM1_BASE + ADDR_W'(3 * STEP));
        check("wrap4", wrap_addr[4], CAM1_BASE);

        // Reset during the data phase abandons the burst
        do_burst(0, 0, 1, 0, 3'b000, 3'b000, 7);
        do_burst(0, 0, 0, 0, 3'b000, 3'b000, -1);
        check("after_rst_addr", obs_addr, CAM1_BASE);
        check("after_rst_grant", obs_gnt, 3'b001);

        // Randomized traffic against the model
        for (int n = 0; n < 40; n++) begin
            r = 3'($urandom_range(1, 7));
            req = r;
            urgent = ($urandom_range(0, 3) == 0);
            do_burst($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                     $urandom_range(0, 1),
                     ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
                     ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
                     -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
